fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_drain_pkg.sv | 15 +
 rtl/fifo_drain_if.sv | 34 +++
 rtl/fifo_drain_skid.sv | 57 +++++
 rtl/fifo_drain.sv | 106 ++++++++++
 tb/tb_fifo_drain.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the fifo_drain block.
// Optional checker build: FIFO_DRAIN_CHECK_EN.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH  = 2;
  localparam int RD_LATENCY = 1;
  localparam int OCC_BITS   = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_drain_if.sv
// FIFO read port plus downstream valid/ready stream used by fifo_drain.
interface fifo_drain_if #(
  parameter int BITS = 32
);

  // FIFO side: p_read_en pops one word, p_read_data is valid one cycle later.
  // Downstream side: a word moves when out_valid && out_ready on a rising
  // edge; once out_valid is high, out_valid and out_data hold until accepted.
  logic            p_read_en;
  logic [BITS-1:0] p_read_data;
  logic            p_read_empty;
  logic            out_valid;
  logic [BITS-1:0] out_data;
  logic            out_ready;

  modport master (
    output p_read_en,
    input  p_read_data,
    input  p_read_empty,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  p_read_en,
    output p_read_data,
    output p_read_empty,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/fifo_drain_skid.sv
// Two-entry in-order skid buffer; head is always entry 0.
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [BITS-1:0]     push_data,
  input  logic                pop,
  output logic [BITS-1:0]     head,
  output logic [OCC_BITS-1:0] occ
);

  localparam logic [OCC_BITS-1:0] OCC_ONE  = OCC_BITS'(1);
  localparam logic [OCC_BITS-1:0] OCC_FULL = OCC_BITS'(BUF_DEPTH);

  logic [BITS-1:0] e0;
  logic [BITS-1:0] e1;

  always_ff @(posedge clk) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      occ <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == '0) e0 <= push_data;
          else           e1 <= push_data;
          occ <= occ + OCC_ONE;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - OCC_ONE;
        end
        2'b11: begin
          // Simultaneous push/pop: the entry behind the head advances first.
          if (occ == OCC_FULL) begin
            e0 <= e1;
            e1 <= push_data;
          end else begin
            e0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = e0;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && occ == OCC_FULL));

endmodule

// File: rtl/fifo_drain.sv
// Drains a 1-cycle-latency FIFO into a valid/ready stream through a skid buffer.
// Build with FIFO_DRAIN_CHECK_EN to add the incrementing-pattern data checker.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  fifo_drain_if.master        bus,
  output logic                busy,
  output logic [CNT_BITS-1:0] word_count,
  output state_t              state_dbg
`ifdef FIFO_DRAIN_CHECK_EN
  ,
  output logic [15:0]         chk_error_count,
  output logic                chk_mismatch
`endif
);

  state_t                state;
  state_t                state_nxt;
  logic [RD_LATENCY-1:0] inflight;
  logic                  rd_en;
  logic                  pop;
  logic [OCC_BITS-1:0]   occ;
  logic [OCC_BITS:0]     occ_future;
  logic [BITS-1:0]       head;
  logic [CNT_BITS-1:0]   cnt;

  fifo_drain_skid #(.BITS(BITS)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight[0]),
    .push_data (bus.p_read_data),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  assign bus.out_valid = !rst && (occ != '0);
  assign bus.out_data  = rst ? '0 : head;
  assign pop           = bus.out_valid && bus.out_ready;

  // Enable is also sampled directly so reads stop in the cycle it falls.
  assign occ_future = (OCC_BITS+1)'(occ) + (OCC_BITS+1)'(inflight) - (OCC_BITS+1)'(pop);
  assign rd_en      = !rst && (state == RUN) && enable && !bus.p_read_empty
                      && (occ_future < (OCC_BITS+1)'(BUF_DEPTH));
  assign bus.p_read_en = rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      inflight <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_en;
      if (pop) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)                              state_nxt = RUN;
        else if (inflight == '0 && occ == '0)    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = !rst && (state == RUN || state == DRAIN);
  assign word_count = rst ? '0 : cnt;
  assign state_dbg  = state;

`ifdef FIFO_DRAIN_CHECK_EN
  logic [BITS-1:0] chk_exp;

  // On a miss, resync to the observed word so one glitch counts once.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_exp         <= '0;
      chk_error_count <= '0;
      chk_mismatch    <= 1'b0;
    end else begin
      chk_mismatch <= 1'b0;
      if (pop) begin
        if (bus.out_data != chk_exp) begin
          chk_mismatch <= 1'b1;
          chk_exp      <= bus.out_data + 1'b1;
          if (chk_error_count != 16'hFFFF) chk_error_count <= chk_error_count + 1'b1;
        end else begin
          chk_exp <= chk_exp + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: FIFO model, transfer monitor, scoreboard.
module tb_fifo_drain;
  import fifo_drain_pkg::*;

  localparam int BITS     = 32;
  localparam int CNT_BITS = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                enable = 1'b0;
  logic                busy;
  logic [CNT_BITS-1:0] word_count;
  state_t              state_dbg;
`ifdef FIFO_DRAIN_CHECK_EN
  logic [15:0]         chk_error_count;
  logic                chk_mismatch;
`endif

  fifo_drain_if #(.BITS(BITS)) bus ();

  fifo_drain #(.BITS(BITS), .CNT_BITS(CNT_BITS)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .bus             (bus),
    .busy            (busy),
    .word_count      (word_count),
    .state_dbg       (state_dbg)
`ifdef FIFO_DRAIN_CHECK_EN
    ,
    .chk_error_count (chk_error_count),
    .chk_mismatch    (chk_mismatch)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- FIFO model (writes from tasks, reads here) ----------------
  logic [BITS-1:0] fifo_mem [0:255];
  logic [7:0]      fifo_wr = 8'd0;
  logic [7:0]      fifo_rd = 8'd0;
  logic [BITS-1:0] rd_data = '0;
  int unsigned     reads_issued = 0;
  int unsigned     empty_reads = 0;

  assign bus.p_read_empty = (fifo_rd == fifo_wr);
  assign bus.p_read_data  = rd_data;

  always @(posedge clk) begin
    if (bus.p_read_en) begin
      reads_issued <= reads_issued + 1;
      if (fifo_rd == fifo_wr) empty_reads <= empty_reads + 1;
      else begin
        rd_data <= fifo_mem[fifo_rd];
        fifo_rd <= fifo_rd + 8'd1;
      end
    end
  end

  // ---------------- transfer monitor ----------------
  int unsigned     cyc = 0;
  logic [BITS-1:0] got_mem [0:255];
  int unsigned     got_cyc [0:255];
  logic [7:0]      got_wr = 8'd0;
  logic [7:0]      got_rd = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      got_mem[got_wr] <= bus.out_data;
      got_cyc[got_wr] <= cyc;
      got_wr          <= got_wr + 8'd1;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [BITS-1:0]     exp_q[$];
  logic [CNT_BITS-1:0] exp_wc = '0;
  int                  vectors = 0;
  int                  miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int first, input int n, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      fifo_mem[fifo_wr] = BITS'(first + i);
      fifo_wr = fifo_wr + 8'd1;
      if (expect_out) exp_q.push_back(BITS'(first + i));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; bus.out_ready = 1'b1;
    tick(); tick();
    vectors++; if (bus.p_read_en !== 1'b0) begin miscompares++; $display("FAIL reset_p_read_en got=%0b exp=0", bus.p_read_en); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    vectors++; if (bus.out_data !== '0) begin miscompares++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    vectors++; if (word_count !== '0) begin miscompares++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
    vectors++; if (state_dbg !== IDLE) begin miscompares++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
    enable = 1'b0; rst = 1'b0;
    tick();
    vectors++; if (state_dbg !== IDLE) begin miscompares++; $display("FAIL reset_release_state got=%0d exp=%0d", state_dbg, IDLE); end
    exp_wc = '0;
  endtask

`ifdef FIFO_DRAIN_CHECK_EN
  task automatic test_checker();
    logic [7:0]  base;
    int          pulses;
    int unsigned pulse_cyc;
    logic [BITS-1:0] e;
    base = got_rd; pulses = 0; pulse_cyc = 0;
    fifo_mem[fifo_wr] = 32'd0; fifo_wr = fifo_wr + 8'd1; exp_q.push_back(32'd0);
    fifo_mem[fifo_wr] = 32'd1; fifo_wr = fifo_wr + 8'd1; exp_q.push_back(32'd1);
    fifo_mem[fifo_wr] = 32'd2; fifo_wr = fifo_wr + 8'd1; exp_q.push_back(32'd2);
    fifo_mem[fifo_wr] = 32'd7; fifo_wr = fifo_wr + 8'd1; exp_q.push_back(32'd7);
    fifo_mem[fifo_wr] = 32'd8; fifo_wr = fifo_wr + 8'd1; exp_q.push_back(32'd8);
    bus.out_ready = 1'b1; enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (chk_mismatch === 1'b1) begin pulses++; pulse_cyc = cyc; end
    end
    enable = 1'b0;
    for (int k = 0; k < 20 && busy; k++) tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL checker_idle_timeout busy=%0b exp=0", busy); end
    vectors++; if (pulses != 1) begin miscompares++; $display("FAIL checker_pulses got=%0d exp=1", pulses); end
    vectors++; if (pulse_cyc != got_cyc[base + 8'd3] + 1) begin miscompares++; $display("FAIL checker_pulse_cycle got=%0d exp=%0d", pulse_cyc, got_cyc[base + 8'd3] + 1); end
    vectors++; if (chk_error_count !== 16'd1) begin miscompares++; $display("FAIL checker_error_count got=%0d exp=1", chk_error_count); end
    while (got_rd != got_wr) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL checker_extra_word got=%0h exp=none", got_mem[got_rd]); end
      else begin
        e = exp_q.pop_front();
        if (got_mem[got_rd] !== e) begin miscompares++; $display("FAIL checker_data got=%0h exp=%0h", got_mem[got_rd], e); end
      end
      got_rd = got_rd + 8'd1;
    end
    exp_wc = exp_wc + 5;
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL checker_missing got=%0d exp=0 left", exp_q.size()); exp_q.delete(); end
    vectors++; if (word_count !== exp_wc) begin miscompares++; $display("FAIL checker_word_count got=%0d exp=%0d", word_count, exp_wc); end
  endtask
`endif

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    preload(100, 10, 1'b0);
    enable = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (bus.p_read_en !== 1'b0) begin miscompares++; $display("FAIL midrst_p_read_en cyc=%0d got=%0b exp=0", k, bus.p_read_en); end
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid cyc=%0d got=%0b exp=0", k, bus.out_valid); end
      vectors++; if (word_count !== '0) begin miscompares++; $display("FAIL midrst_word_count cyc=%0d got=%0d exp=0", k, word_count); end
      tick();
    end
    rst = 1'b0;
    #1;
    vectors++; if (bus.p_read_en !== 1'b0) begin miscompares++; $display("FAIL midrst_release_p_read_en got=%0b exp=0", bus.p_read_en); end
    vectors++; if (state_dbg !== IDLE) begin miscompares++; $display("FAIL midrst_release_state got=%0d exp=%0d", state_dbg, IDLE); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_release_out_valid got=%0b exp=0", bus.out_valid); end
    enable = 1'b0;
    tick();
    fifo_wr = fifo_rd;
    exp_wc = '0;
    tick();
  endtask

  task automatic test_streaming();
    logic [7:0]  base;
    int unsigned base_reads, base_empty, en_cyc;
    int          gaps;
    logic [BITS-1:0] e;
    base = got_rd; base_reads = reads_issued; base_empty = empty_reads; gaps = 0;
    bus.out_ready = 1'b1;
    preload(0, 16, 1'b1);
    enable = 1'b1; en_cyc = cyc;
    for (int k = 0; k < 60 && 8'(got_wr - base) != 8'd16; k++) tick();
    vectors++; if (8'(got_wr - base) != 8'd16) begin miscompares++; $display("FAIL stream_count got=%0d exp=16", 8'(got_wr - base)); end
    vectors++; if (got_cyc[base] != en_cyc + 3) begin miscompares++; $display("FAIL stream_first_cycle got=%0d exp=%0d", got_cyc[base], en_cyc + 3); end
    for (int i = 1; i < 16; i++) if (got_cyc[base + 8'(i)] != got_cyc[base + 8'(i - 1)] + 1) gaps++;
    vectors++; if (gaps != 0) begin miscompares++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
    while (got_rd != got_wr) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL stream_extra_word got=%0h exp=none", got_mem[got_rd]); end
      else begin
        e = exp_q.pop_front();
        if (got_mem[got_rd] !== e) begin miscompares++; $display("FAIL stream_data got=%0h exp=%0h", got_mem[got_rd], e); end
      end
      got_rd = got_rd + 8'd1;
    end
    exp_wc = exp_wc + 16;
    tick(); tick();
    vectors++; if (word_count !== exp_wc) begin miscompares++; $display("FAIL stream_word_count got=%0d exp=%0d", word_count, exp_wc); end
    vectors++; if (bus.p_read_empty !== 1'b1) begin miscompares++; $display("FAIL stream_fifo_empty got=%0b exp=1", bus.p_read_empty); end
    vectors++; if (empty_reads != base_empty) begin miscompares++; $display("FAIL stream_empty_reads got=%0d exp=%0d", empty_reads, base_empty); end
    vectors++; if (reads_issued - base_reads != 16) begin miscompares++; $display("FAIL stream_reads got=%0d exp=16", reads_issued - base_reads); end
    enable = 1'b0;
    for (int k = 0; k < 20 && busy; k++) tick();
    vectors++; if (state_dbg !== IDLE) begin miscompares++; $display("FAIL stream_final_state got=%0d exp=%0d", state_dbg, IDLE); end
  endtask

  task automatic test_backpressure();
    logic [7:0]      base;
    logic [3:0]      pat;
    logic            prev_stall;
    logic [BITS-1:0] prev_data, e;
    base = got_rd; pat = 4'b1001; prev_stall = 1'b0; prev_data = '0;
    preload(0, 8, 1'b1);
    enable = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (prev_stall) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
          miscompares++;
          $display("FAIL bp_stall_hold got=%0b/%0h exp=1/%0h", bus.out_valid, bus.out_data, prev_data);
        end
      end
      bus.out_ready = pat[i % 4];
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
    vectors++; if (8'(got_wr - base) != 8'd8) begin miscompares++; $display("FAIL bp_count got=%0d exp=8", 8'(got_wr - base)); end
    while (got_rd != got_wr) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL bp_extra_word got=%0h exp=none", got_mem[got_rd]); end
      else begin
        e = exp_q.pop_front();
        if (got_mem[got_rd] !== e) begin miscompares++; $display("FAIL bp_data got=%0h exp=%0h", got_mem[got_rd], e); end
      end
      got_rd = got_rd + 8'd1;
    end
    exp_wc = exp_wc + 8;
    enable = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && busy; k++) tick();
    vectors++; if (word_count !== exp_wc) begin miscompares++; $display("FAIL bp_word_count got=%0d exp=%0d", word_count, exp_wc); end
  endtask

  task automatic test_stop();
    logic [7:0]  base;
    int unsigned base_reads;
    int          late_reads, got_at_fall;
    bit          dropped;
    logic [BITS-1:0] e;
    base = got_rd; base_reads = reads_issued; late_reads = 0; got_at_fall = -1; dropped = 1'b0;
    bus.out_ready = 1'b1;
    preload(0, 5, 1'b1);
    preload(5, 7, 1'b0);
    enable = 1'b1;
    for (int k = 0; k < 30 && !dropped; k++) begin
      tick();
      if (reads_issued - base_reads == 5) begin
        enable = 1'b0; dropped = 1'b1;
        #1;
        vectors++; if (bus.p_read_en !== 1'b0) begin miscompares++; $display("FAIL stop_p_read_en_same_cycle got=%0b exp=0", bus.p_read_en); end
      end
    end
    vectors++; if (!dropped) begin miscompares++; $display("FAIL stop_reads_timeout got=%0d exp=5", reads_issued - base_reads); end
    for (int k = 0; k < 30 && got_at_fall < 0; k++) begin
      tick();
      if (bus.p_read_en) late_reads++;
      if (!busy) got_at_fall = 8'(got_wr - base);
    end
    vectors++; if (got_at_fall != 5) begin miscompares++; $display("FAIL stop_busy_fall got=%0d words exp=5", got_at_fall); end
    vectors++; if (late_reads != 0) begin miscompares++; $display("FAIL stop_late_reads got=%0d exp=0", late_reads); end
    vectors++; if (reads_issued - base_reads != 5) begin miscompares++; $display("FAIL stop_reads got=%0d exp=5", reads_issued - base_reads); end
    while (got_rd != got_wr) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL stop_extra_word got=%0h exp=none", got_mem[got_rd]); end
      else begin
        e = exp_q.pop_front();
        if (got_mem[got_rd] !== e) begin miscompares++; $display("FAIL stop_data got=%0h exp=%0h", got_mem[got_rd], e); end
      end
      got_rd = got_rd + 8'd1;
    end
    exp_wc = exp_wc + 5;
    vectors++; if (word_count !== exp_wc) begin miscompares++; $display("FAIL stop_word_count got=%0d exp=%0d", word_count, exp_wc); end
    fifo_wr = fifo_rd;
    tick();
  endtask

  task automatic test_empty_edge();
    logic [7:0]  base;
    int unsigned base_reads, base_empty;
    logic [BITS-1:0] e;
    base = got_rd; base_reads = reads_issued; base_empty = empty_reads;
    bus.out_ready = 1'b1;
    preload(32'hA5, 1, 1'b1);
    enable = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    vectors++; if (reads_issued - base_reads != 1) begin miscompares++; $display("FAIL edge_reads got=%0d exp=1", reads_issued - base_reads); end
    vectors++; if (empty_reads != base_empty) begin miscompares++; $display("FAIL edge_empty_reads got=%0d exp=%0d", empty_reads, base_empty); end
    vectors++; if (8'(got_wr - base) != 8'd1) begin miscompares++; $display("FAIL edge_count got=%0d exp=1", 8'(got_wr - base)); end
    while (got_rd != got_wr) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL edge_extra_word got=%0h exp=none", got_mem[got_rd]); end
      else begin
        e = exp_q.pop_front();
        if (got_mem[got_rd] !== e) begin miscompares++; $display("FAIL edge_data got=%0h exp=%0h", got_mem[got_rd], e); end
      end
      got_rd = got_rd + 8'd1;
    end
    exp_wc = exp_wc + 1;
    enable = 1'b0;
    for (int k = 0; k < 20 && busy; k++) tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL edge_idle got=%0b exp=0", busy); end
    vectors++; if (word_count !== exp_wc) begin miscompares++; $display("FAIL edge_word_count got=%0d exp=%0d", word_count, exp_wc); end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
`ifdef FIFO_DRAIN_CHECK_EN
    test_checker();
`endif
    test_reset_mid();
    test_streaming();
    test_backpressure();
    test_stop();
    test_empty_edge();
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL final_exp_queue got=%0d exp=0 left", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
